ysyx_22040127_ifu: RTL and testbench

YSYX_22040127_IFU -- requirements
Module: ysyx_22040127_ifu

---
 rtl/ysyx_22040127_ifu_pkg.sv | 16 +
 rtl/ysyx_22040127_fifo.sv | 46 ++++
 rtl/ysyx_22040127_ifu.sv | 94 +++++++++
 tb/tb_ysyx_22040127_ifu.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040127_ifu_pkg.sv
// ysyx_22040127_ifu_pkg: constants and types shared by the fetch unit and the decode stage.
package ysyx_22040127_ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam int IF_TO_ID_WIDTH = 64;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } if_to_id_t;

    function automatic logic [31:0] sel_inst(input logic hi, input logic [63:0] data);
        return hi ? data[63:32] : data[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22040127_fifo.sv
// ysyx_22040127_fifo: synchronous FIFO with flush; depth must be a power of two so pointers wrap naturally.
module ysyx_22040127_fifo #(
    parameter int W = 64,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [W-1:0]         din_i,
    input  logic                 pop_i,
    output logic [W-1:0]         dout_o,
    output logic                 empty_o,
    output logic [$clog2(D):0]   count_o
);

    localparam int PW = $clog2(D);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q;
    logic          do_push, do_pop;

    assign do_push = push_i && (cnt_q != (PW+1)'(D));
    assign do_pop  = pop_i && (cnt_q != '0);
    assign dout_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + PW'(do_push);
            rptr_q <= rptr_q + PW'(do_pop);
            cnt_q  <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/ysyx_22040127_ifu.sv
// ysyx_22040127_ifu: instruction fetch with credit-limited requests, in-order PC tags,
// a fetch queue toward decode, and redirect/branch flush with stale-response dropping.
module ysyx_22040127_ifu
    import ysyx_22040127_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          FQ_DEPTH = 4,
    parameter int          AW       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_valid,
    input  logic [AW-1:0]             redirect_pc,
    input  logic                      branch_valid,
    input  logic [AW-1:0]             branch_pc,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [AW-1:0]             imem_req_addr,
    input  logic                      imem_resp_valid,
    input  logic [63:0]               imem_resp_data,
    output logic                      if_to_id_valid,
    input  logic                      id_allowin,
    output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
    output logic [AW-1:0]             if_pc
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d;
    logic [CW-1:0] fq_cnt, unused_tag_cnt;
    logic [AW-1:0] tag_pc;
    logic          tag_empty, fq_empty;
    logic          flush, credit_ok, req_fire, resp, resp_keep, deq;
    if_to_id_t     fq_din, fq_head;

    assign flush     = !rst && (redirect_valid || branch_valid);
    assign credit_ok = ({1'b0, out_q} + {1'b0, fq_cnt}) < (CW+1)'(FQ_DEPTH);
    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp      = !rst && imem_resp_valid;
    // responses for requests issued before a flush are still in flight; drop_q counts them off
    assign resp_keep = resp && !flush && (drop_q == '0) && !tag_empty;
    assign deq       = if_to_id_valid && id_allowin;

    assign imem_req_valid = !rst && !flush && credit_ok;
    assign imem_req_addr  = {pc_q[AW-1:3], 3'b000};
    assign if_pc          = pc_q;
    assign if_to_id_valid = !rst && !fq_empty;
    assign if_to_id_bus   = if_to_id_valid ? fq_head : '0;
    assign fq_din         = '{inst: sel_inst(tag_pc[2], imem_resp_data), pc: tag_pc[31:0]};

    always_comb begin
        pc_d   = redirect_valid ? redirect_pc : branch_valid ? branch_pc : req_fire ? pc_q + AW'(4) : pc_q;
        out_d  = out_q + CW'(req_fire) - CW'(resp);
        drop_d = flush ? out_q - CW'(resp) : (resp && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= AW'(RESET_PC);
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            drop_q <= drop_d;
        end
    end

    ysyx_22040127_fifo #(.W(AW), .D(FQ_DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (req_fire),
        .din_i   (pc_q),
        .pop_i   (resp_keep),
        .dout_o  (tag_pc),
        .empty_o (tag_empty),
        .count_o (unused_tag_cnt)
    );

    ysyx_22040127_fifo #(.W(IF_TO_ID_WIDTH), .D(FQ_DEPTH)) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (resp_keep),
        .din_i   (fq_din),
        .pop_i   (deq),
        .dout_o  (fq_head),
        .empty_o (fq_empty),
        .count_o (fq_cnt)
    );

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// tb_ysyx_22040127_ifu: directed fetch scenarios against a latency-configurable memory model,
// with an expected-bus queue drained by an independent dequeue monitor.
module tb_ysyx_22040127_ifu;

    logic        clk = 0;
    logic        rst;
    logic        redirect_valid, branch_valid;
    logic [31:0] redirect_pc, branch_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [63:0] imem_resp_data;
    logic        if_to_id_valid, id_allowin;
    logic [63:0] if_to_id_bus;
    logic [31:0] if_pc;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    ysyx_22040127_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .branch_valid    (branch_valid),
        .branch_pc       (branch_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_to_id_valid  (if_to_id_valid),
        .id_allowin      (id_allowin),
        .if_to_id_bus    (if_to_id_bus),
        .if_pc           (if_pc)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({inst_of(base + 32'(4 * i)), base + 32'(4 * i)});
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0) return;
        end
        checks++;
        failures++;
        $display("FAIL drain_timeout actual=%0d required=0 entries left", exp_q.size());
    endtask

    task automatic do_reset();
        rst = 1;
        redirect_valid = 0;
        branch_valid = 0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_id_valid", 64'(if_to_id_valid), 64'd0);
        chk("rst_bus", if_to_id_bus, 64'd0);
        tick();
        @(negedge clk);
        chk("rst_if_pc", 64'(if_pc), 64'h8000_0000);
        tick();
        rst = 0;
    endtask

    // memory: one response per cycle, in order, lat cycles after acceptance
    initial begin
        imem_resp_valid = 0;
        imem_resp_data = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                imem_resp_valid = 1;
                imem_resp_data = {inst_of(pend[0].addr + 32'd4), inst_of(pend[0].addr)};
                void'(pend.pop_front());
            end else begin
                imem_resp_valid = 0;
                imem_resp_data = '0;
            end
            @(negedge clk);
            if (rst) pend.delete();
            else if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + lat});
        end
    end

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && if_to_id_valid && id_allowin) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%h required=no dequeue", if_to_id_bus);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_bus", if_to_id_bus, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        redirect_valid = 0;
        branch_valid = 0;
        redirect_pc = '0;
        branch_pc = '0;
        imem_req_ready = 1;
        id_allowin = 0;
        tick();

        // sequential fetch, 1-cycle memory, decode always ready
        lat = 1;
        id_allowin = 1;
        do_reset();
        push_seq(32'h8000_0000, 8);
        @(negedge clk);
        chk("a_req_valid", 64'(imem_req_valid), 64'd1);
        chk("a_req_addr0", 64'(imem_req_addr), 64'h8000_0000);
        chk("a_id_valid_c0", 64'(if_to_id_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("a_if_pc_c1", 64'(if_pc), 64'h8000_0004);
        chk("a_req_addr1", 64'(imem_req_addr), 64'h8000_0000);
        chk("a_id_valid_c1", 64'(if_to_id_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("a_id_valid_c2", 64'(if_to_id_valid), 64'd1);
        chk("a_bus_c2", if_to_id_bus, {inst_of(32'h8000_0000), 32'h8000_0000});
        drain(60);
        id_allowin = 0;

        // decode stalled: queue fills to depth and requests stop
        lat = 1;
        do_reset();
        repeat (12) tick();
        @(negedge clk);
        chk("b_id_valid_full", 64'(if_to_id_valid), 64'd1);
        chk("b_req_stopped", 64'(imem_req_valid), 64'd0);
        chk("b_if_pc_4_reqs", 64'(if_pc), 64'h8000_0010);
        tick();
        push_seq(32'h8000_0000, 8);
        id_allowin = 1;
        drain(60);
        id_allowin = 0;

        // 3-cycle memory, branch with 3 outstanding (oldest arriving the same cycle)
        lat = 3;
        do_reset();
        repeat (3) tick();
        branch_valid = 1;
        branch_pc = 32'h8000_0100;
        @(negedge clk);
        chk("c_req_suppressed", 64'(imem_req_valid), 64'd0);
        chk("c_if_pc_pre", 64'(if_pc), 64'h8000_000C);
        tick();
        branch_valid = 0;
        @(negedge clk);
        chk("c_if_pc_target", 64'(if_pc), 64'h8000_0100);
        chk("c_req_addr_target", 64'(imem_req_addr), 64'h8000_0100);
        chk("c_id_valid_c4", 64'(if_to_id_valid), 64'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("c_id_valid_c7", 64'(if_to_id_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("c_id_valid_c8", 64'(if_to_id_valid), 64'd1);
        chk("c_bus_first", if_to_id_bus, {inst_of(32'h8000_0100), 32'h8000_0100});
        tick();
        push_seq(32'h8000_0100, 8);
        id_allowin = 1;
        drain(80);
        id_allowin = 0;

        // redirect beats branch; the response landing in that cycle is discarded
        lat = 1;
        do_reset();
        tick();
        redirect_valid = 1;
        redirect_pc = 32'h8000_0040;
        branch_valid = 1;
        branch_pc = 32'h8000_0100;
        @(negedge clk);
        chk("d_req_suppressed", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 0;
        branch_valid = 0;
        @(negedge clk);
        chk("d_if_pc_redirect", 64'(if_pc), 64'h8000_0040);
        chk("d_id_valid_c2", 64'(if_to_id_valid), 64'd0);
        chk("d_req_valid_c2", 64'(imem_req_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("d_id_valid_c3", 64'(if_to_id_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("d_id_valid_c4", 64'(if_to_id_valid), 64'd1);
        chk("d_bus_first", if_to_id_bus, {inst_of(32'h8000_0040), 32'h8000_0040});
        tick();
        push_seq(32'h8000_0040, 8);
        id_allowin = 1;
        drain(60);
        id_allowin = 0;

        // flush with a non-empty queue: head gone next cycle even with decode ready
        lat = 2;
        do_reset();
        exp_q.push_back({inst_of(32'h8000_0000), 32'h8000_0000});
        repeat (4) tick();
        branch_valid = 1;
        branch_pc = 32'h8000_0200;
        id_allowin = 1;
        @(negedge clk);
        chk("e_id_valid_pre", 64'(if_to_id_valid), 64'd1);
        tick();
        branch_valid = 0;
        @(negedge clk);
        chk("e_id_valid_post_flush", 64'(if_to_id_valid), 64'd0);
        chk("e_if_pc_target", 64'(if_pc), 64'h8000_0200);
        push_seq(32'h8000_0200, 6);
        drain(60);
        id_allowin = 0;

        // reset in the middle of traffic, then refetch from the reset PC
        lat = 2;
        do_reset();
        repeat (4) tick();
        @(negedge clk);
        chk("f_id_valid_busy", 64'(if_to_id_valid), 64'd1);
        chk("f_req_credit_out", 64'(imem_req_valid), 64'd0);
        tick();
        do_reset();
        push_seq(32'h8000_0000, 6);
        id_allowin = 1;
        @(negedge clk);
        chk("f_refetch_valid", 64'(imem_req_valid), 64'd1);
        chk("f_refetch_addr", 64'(imem_req_addr), 64'h8000_0000);
        drain(60);
        id_allowin = 0;

        // memory not ready: address and PC held
        lat = 1;
        imem_req_ready = 0;
        do_reset();
        repeat (2) tick();
        @(negedge clk);
        chk("g_req_held_valid", 64'(imem_req_valid), 64'd1);
        chk("g_req_held_addr", 64'(imem_req_addr), 64'h8000_0000);
        chk("g_if_pc_held", 64'(if_pc), 64'h8000_0000);
        tick();
        imem_req_ready = 1;
        push_seq(32'h8000_0000, 6);
        id_allowin = 1;
        drain(60);
        id_allowin = 0;

        tick();
        chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
